// File: rtl/vrf_result_write_arbiter_pkg.sv
// Shared types and helpers for the VRF result write arbiter.
package vrf_result_write_arbiter_pkg;

  localparam int unsigned NrVRFBanks = 8;
  localparam int unsigned VAddrW     = 16;
  localparam int unsigned VidW       = 3;
  localparam int unsigned ELEN       = 64;
  localparam int unsigned StrbW      = ELEN / 8;

  typedef logic [VAddrW-1:0] vaddr_t;
  typedef logic [VidW-1:0]   vid_t;
  typedef logic [ELEN-1:0]   elen_t;
  typedef logic [StrbW-1:0]  strb_t;

  // One buffered result write.
  typedef struct packed {
    vaddr_t addr;
    vid_t   id;
    elen_t  wdata;
    strb_t  be;
  } wreq_t;

  // Bank index = low log2(nbanks) address bits; nbanks is a power of two.
  function automatic int unsigned vrf_bank_sel(input vaddr_t addr, input int unsigned nbanks);
    return 32'(addr) & (nbanks - 32'd1);
  endfunction

endpackage

// File: rtl/vrf_result_write_arbiter_wbuf.sv
// Per-requester write buffer: small power-of-two FIFO of result writes.
module vrf_wbuf
  import vrf_result_write_arbiter_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  push_i,
  input  wreq_t data_i,
  input  logic  pop_i,
  output wreq_t data_o,
  output logic  full_o,
  output logic  empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  wreq_t            mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [PtrW:0]    cnt_q, cnt_d;

  assign full_o  = (cnt_q == (PtrW+1)'(Depth));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rptr_q];

  // Pointer/count update; Depth is a power of two so pointers wrap naturally.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_i) wptr_d = wptr_q + 1'b1;
    if (pop_i)  rptr_d = rptr_q + 1'b1;
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state, cleared by reset (drops any buffered writes).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Payload storage; contents only matter while the count says so.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/vrf_result_write_arbiter.sv
// Lane-local VRF result write arbiter: per-requester FIFOs feeding one
// round-robin arbiter and one registered valid/ready write port per bank.
module vrf_result_write_arbiter
  import vrf_result_write_arbiter_pkg::*;
#(
  parameter int unsigned NrReq    = 3,
  parameter int unsigned NrBanks  = NrVRFBanks,
  parameter int unsigned BufDepth = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NrReq-1:0]                 req_i,
  input  logic [NrReq-1:0][VAddrW-1:0]     addr_i,
  input  logic [NrReq-1:0][VidW-1:0]       id_i,
  input  logic [NrReq-1:0][ELEN-1:0]       wdata_i,
  input  logic [NrReq-1:0][StrbW-1:0]      be_i,
  output logic [NrReq-1:0]                 gnt_o,
  output logic [NrBanks-1:0]               bank_we_o,
  input  logic [NrBanks-1:0]               bank_ready_i,
  output logic [NrBanks-1:0][VAddrW-1:0]   bank_addr_o,
  output logic [NrBanks-1:0][ELEN-1:0]     bank_wdata_o,
  output logic [NrBanks-1:0][StrbW-1:0]    bank_be_o,
  output logic [NrBanks-1:0][VidW-1:0]     bank_id_o
);

  localparam int unsigned BankW = $clog2(NrBanks);
  localparam int unsigned ReqW  = (NrReq > 1) ? $clog2(NrReq) : 1;

  wreq_t [NrReq-1:0]              wr_in;
  wreq_t [NrReq-1:0]              head;
  logic  [NrReq-1:0]              full, empty, push, pop;

  logic  [NrBanks-1:0][NrReq-1:0] cand;
  logic  [NrBanks-1:0]            win_vld, load;
  logic  [NrBanks-1:0][ReqW-1:0]  win_idx;
  logic  [NrBanks-1:0][ReqW-1:0]  rr_q, rr_d;

  logic  [NrBanks-1:0]            we_q, we_d;
  wreq_t [NrBanks-1:0]            out_q, out_d;

  // Accept: grant whenever there is room, including a same-cycle pop on a
  // full FIFO. Held off during reset so nothing is acknowledged and lost.
  always_comb begin
    push = '0;
    for (int unsigned r = 0; r < NrReq; r++) begin
      push[r] = rst_ni & req_i[r] & (~full[r] | pop[r]);
    end
  end

  assign gnt_o = push;

  // Per-requester buffers.
  for (genvar r = 0; r < NrReq; r++) begin : g_req
    assign wr_in[r] = '{addr: addr_i[r], id: id_i[r], wdata: wdata_i[r], be: be_i[r]};

    vrf_wbuf #(
      .Depth (BufDepth)
    ) u_wbuf (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (push[r]),
      .data_i  (wr_in[r]),
      .pop_i   (pop[r]),
      .data_o  (head[r]),
      .full_o  (full[r]),
      .empty_o (empty[r])
    );
  end

  // Candidate matrix: every non-empty head requests exactly one bank.
  always_comb begin
    cand = '0;
    for (int unsigned b = 0; b < NrBanks; b++) begin
      for (int unsigned r = 0; r < NrReq; r++) begin
        cand[b][r] = ~empty[r] & (vrf_bank_sel(head[r].addr, NrBanks) == b);
      end
    end
  end

  // Per-bank round-robin pick starting at rr_q; the bank register loads
  // when empty or draining, and only a real load pops a FIFO and moves rr.
  always_comb begin
    int unsigned idx;
    win_vld = '0;
    win_idx = '0;
    load    = '0;
    pop     = '0;
    rr_d    = rr_q;
    idx     = 0;
    for (int unsigned b = 0; b < NrBanks; b++) begin
      for (int unsigned off = 0; off < NrReq; off++) begin
        idx = 32'(rr_q[b]) + off;
        if (idx >= NrReq) idx = idx - NrReq;
        if (!win_vld[b] && cand[b][ReqW'(idx)]) begin
          win_vld[b] = 1'b1;
          win_idx[b] = ReqW'(idx);
        end
      end
      load[b] = win_vld[b] & (~we_q[b] | bank_ready_i[b]);
      if (load[b]) begin
        pop[win_idx[b]] = 1'b1;
        rr_d[b] = (32'(win_idx[b]) == NrReq - 1) ? '0 : win_idx[b] + 1'b1;
      end
    end
  end

  // Bank output register next state: hold while stalled, otherwise take the
  // winner (or go idle). Row address drops the bank-select bits.
  always_comb begin
    we_d  = we_q;
    out_d = out_q;
    for (int unsigned b = 0; b < NrBanks; b++) begin
      if (~we_q[b] | bank_ready_i[b]) begin
        we_d[b] = win_vld[b];
      end
      if (load[b]) begin
        out_d[b]      = head[win_idx[b]];
        out_d[b].addr = head[win_idx[b]].addr >> BankW;
      end
    end
  end

  // Bank registers and RR pointers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q  <= '0;
      out_q <= '0;
      rr_q  <= '0;
    end else begin
      we_q  <= we_d;
      out_q <= out_d;
      rr_q  <= rr_d;
    end
  end

  assign bank_we_o = we_q;

  for (genvar b = 0; b < NrBanks; b++) begin : g_bank
    assign bank_addr_o[b]  = out_q[b].addr;
    assign bank_wdata_o[b] = out_q[b].wdata;
    assign bank_be_o[b]    = out_q[b].be;
    assign bank_id_o[b]    = out_q[b].id;
  end

endmodule

// File: tb/tb_vrf_result_write_arbiter.sv
// Self-checking bench: directed scenarios plus a randomized run against a
// queue-based scoreboard of accepted writes.
module tb_vrf_result_write_arbiter;
  import vrf_result_write_arbiter_pkg::*;

  localparam int NR = 3;
  localparam int NB = 8;
  localparam int BD = 2;

  logic                        clk = 1'b0;
  logic                        rst_n = 1'b0;
  logic [NR-1:0]               req = '0;
  logic [NR-1:0][VAddrW-1:0]   addr = '0;
  logic [NR-1:0][VidW-1:0]     id = '0;
  logic [NR-1:0][ELEN-1:0]     wdata = '0;
  logic [NR-1:0][StrbW-1:0]    be = '0;
  logic [NR-1:0]               gnt;
  logic [NB-1:0]               we;
  logic [NB-1:0]               rdy = '0;
  logic [NB-1:0][VAddrW-1:0]   b_addr;
  logic [NB-1:0][ELEN-1:0]     b_wdata;
  logic [NB-1:0][StrbW-1:0]    b_be;
  logic [NB-1:0][VidW-1:0]     b_id;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    int     b;
    int     seq;
    vaddr_t addr;
    vid_t   id;
    elen_t  data;
    strb_t  be;
  } exp_t;

  exp_t outq [NR][$];

  vrf_result_write_arbiter #(.NrReq(NR), .NrBanks(NB), .BufDepth(BD)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_i        (req),
    .addr_i       (addr),
    .id_i         (id),
    .wdata_i      (wdata),
    .be_i         (be),
    .gnt_o        (gnt),
    .bank_we_o    (we),
    .bank_ready_i (rdy),
    .bank_addr_o  (b_addr),
    .bank_wdata_o (b_wdata),
    .bank_be_o    (b_be),
    .bank_id_o    (b_id)
  );

  always #5 clk = ~clk;

  task automatic idle();
    req = '0; addr = '0; id = '0; wdata = '0; be = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rdy = '1; req = '1;
    @(negedge clk); @(negedge clk); #1;
    n_chk++; if (gnt !== '0) $display("FAIL reset_gnt got %b want 0", gnt); else n_pass++;
    n_chk++; if (we !== '0) $display("FAIL reset_we got %h want 0", we); else n_pass++;
    n_chk++;
    if ({b_addr, b_wdata, b_be, b_id} !== '0) $display("FAIL reset_bank_data nonzero bank payload");
    else n_pass++;
    @(negedge clk); idle(); rst_n = 1'b1; #1;
  endtask

  task automatic test_single();
    @(negedge clk); idle(); rdy = '1;
    req[0] = 1'b1; addr[0] = 16'h0009; wdata[0] = 64'hA5; be[0] = 8'hFF; id[0] = 3'd5;
    #1;
    n_chk++; if (gnt !== 3'b001) $display("FAIL single_gnt got %b want 001", gnt); else n_pass++;
    @(negedge clk); idle(); #1;
    n_chk++; if (we !== '0) $display("FAIL single_t1_we got %h want 00", we); else n_pass++;
    @(negedge clk); #1;
    n_chk++; if (we !== 8'h02) $display("FAIL single_t2_we got %h want 02", we); else n_pass++;
    n_chk++;
    if (b_addr[1] !== 16'h1 || b_wdata[1] !== 64'hA5 || b_be[1] !== 8'hFF || b_id[1] !== 3'd5)
      $display("FAIL single_payload got addr=%h data=%h be=%h id=%0d want 1/a5/ff/5",
               b_addr[1], b_wdata[1], b_be[1], b_id[1]);
    else n_pass++;
    @(negedge clk); #1;
    n_chk++; if (we !== '0) $display("FAIL single_t3_we got %h want 00", we); else n_pass++;
  endtask

  task automatic test_bank_conflict();
    int sent [NR];
    int nw, first, last;
    nw = 0; first = -1; last = -1;
    for (int r = 0; r < NR; r++) sent[r] = 0;
    for (int cyc = 0; cyc < 60 && nw < 18; cyc++) begin
      @(negedge clk); rdy = '1;
      for (int r = 0; r < NR; r++) begin
        req[r]   = (sent[r] < 6);
        addr[r]  = 16'((sent[r] << 3) | 3);
        wdata[r] = {8'(r), 8'd3, 16'(sent[r]), 32'h0};
        be[r]    = 8'hFF;
        id[r]    = 3'(r);
      end
      #1;
      for (int r = 0; r < NR; r++) if (gnt[r]) sent[r]++;
      if (we != '0) begin
        n_chk++; if (we !== 8'h08) $display("FAIL conflict_mask got %h want 08", we); else n_pass++;
        n_chk++;
        if (b_wdata[3][63:56] !== 8'(nw % 3) || b_wdata[3][47:32] !== 16'(nw / 3) ||
            b_addr[3] !== 16'(nw / 3))
          $display("FAIL conflict_order write %0d got req=%0d seq=%0d row=%0d want req=%0d seq=%0d",
                   nw, b_wdata[3][63:56], b_wdata[3][47:32], b_addr[3], nw % 3, nw / 3);
        else n_pass++;
        if (first < 0) first = cyc;
        last = cyc;
        nw++;
      end
    end
    idle();
    n_chk++; if (nw !== 18) $display("FAIL conflict_count got %0d want 18", nw); else n_pass++;
    n_chk++; if (last - first !== 17) $display("FAIL conflict_rate span got %0d want 17", last - first); else n_pass++;
  endtask

  task automatic test_parallel();
    @(negedge clk); idle(); rdy = '1;
    for (int r = 0; r < NR; r++) begin
      req[r] = 1'b1; addr[r] = 16'(((r + 4) << 3) | r);
      wdata[r] = {8'(r), 8'(r), 16'h0, 32'h1234_0000 + 32'(r)}; be[r] = 8'h0F; id[r] = 3'(r + 1);
    end
    #1;
    n_chk++; if (gnt !== 3'b111) $display("FAIL parallel_gnt got %b want 111", gnt); else n_pass++;
    @(negedge clk); idle(); #1;
    @(negedge clk); #1;
    n_chk++; if (we !== 8'h07) $display("FAIL parallel_we got %h want 07", we); else n_pass++;
    for (int r = 0; r < NR; r++) begin
      n_chk++;
      if (b_addr[r] !== 16'(r + 4) || b_wdata[r][31:0] !== 32'h1234_0000 + 32'(r) || b_id[r] !== 3'(r + 1))
        $display("FAIL parallel_payload bank %0d got addr=%h data=%h id=%0d", r, b_addr[r], b_wdata[r], b_id[r]);
      else n_pass++;
    end
    @(negedge clk); #1;
  endtask

  task automatic test_backpressure();
    int sent, got;
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk); idle(); rdy = '1; rdy[5] = 1'b0;
      req[1] = (sent < 4); addr[1] = 16'(((10 + sent) << 3) | 5);
      wdata[1] = {8'd1, 8'd5, 16'(sent), 32'hCAFE_0000}; be[1] = 8'h3C; id[1] = 3'd2;
      #1;
      if (gnt[1]) sent++;
      if (cyc >= 2) begin
        n_chk++;
        if (we !== 8'h20 || b_addr[5] !== 16'd10 || b_wdata[5] !== {8'd1, 8'd5, 16'd0, 32'hCAFE_0000} || b_be[5] !== 8'h3C)
          $display("FAIL stall_hold cyc %0d got we=%h addr=%0d data=%h", cyc, we, b_addr[5], b_wdata[5]);
        else n_pass++;
      end
    end
    n_chk++; if (sent !== 3) $display("FAIL stall_gnts got %0d want 3", sent); else n_pass++;
    for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
      @(negedge clk); idle(); rdy = '1;
      req[1] = (sent < 4); addr[1] = 16'(((10 + sent) << 3) | 5);
      wdata[1] = {8'd1, 8'd5, 16'(sent), 32'hCAFE_0000}; be[1] = 8'h3C; id[1] = 3'd2;
      #1;
      if (gnt[1]) sent++;
      if (we[5]) begin
        n_chk++;
        if (b_wdata[5][47:32] !== 16'(got) || b_addr[5] !== 16'(10 + got))
          $display("FAIL stall_drain got seq=%0d row=%0d want seq=%0d", b_wdata[5][47:32], b_addr[5], got);
        else n_pass++;
        got++;
      end
    end
    idle();
    n_chk++; if (got !== 4) $display("FAIL stall_drain_count got %0d want 4", got); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int nw;
    nw = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk); rdy = '1; rdy[6] = 1'b0;
      for (int r = 0; r < NR; r++) begin
        req[r] = 1'b1; addr[r] = 16'((r << 3) | 6); wdata[r] = {8'(r), 56'h77}; be[r] = 8'hFF; id[r] = 3'(r);
      end
      #1;
    end
    n_chk++; if (we[6] !== 1'b1) $display("FAIL rstmid_pre got we=%h want bit6", we); else n_pass++;
    @(negedge clk); idle(); rst_n = 1'b0; #1;
    n_chk++;
    if (gnt !== '0 || we !== '0 || {b_addr, b_wdata, b_be, b_id} !== '0)
      $display("FAIL rstmid_outputs got gnt=%b we=%h", gnt, we);
    else n_pass++;
    @(negedge clk); rst_n = 1'b1; rdy = '1; #1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk); #1;
      n_chk++; if (we !== '0) $display("FAIL rstmid_ghost cyc %0d got we=%h want 00", cyc, we); else n_pass++;
    end
    // New simultaneous burst: RR pointer must be back at requester 0.
    @(negedge clk);
    for (int r = 0; r < NR; r++) begin
      req[r] = 1'b1; addr[r] = 16'((r << 3) | 6); wdata[r] = {8'(r), 56'h88}; be[r] = 8'hFF; id[r] = 3'(r);
    end
    #1;
    for (int cyc = 0; cyc < 12 && nw < 3; cyc++) begin
      @(negedge clk); idle(); #1;
      if (we[6]) begin
        n_chk++;
        if (b_wdata[6][63:56] !== 8'(nw))
          $display("FAIL rstmid_rr write %0d got req=%0d want %0d", nw, b_wdata[6][63:56], nw);
        else n_pass++;
        nw++;
      end
    end
    n_chk++; if (nw !== 3) $display("FAIL rstmid_count got %0d want 3", nw); else n_pass++;
  endtask

  task automatic test_random();
    exp_t cur [NR];
    bit   has [NR];
    int   seqc [NR], waitc [NR], starve [NR];
    int   w, k, ncyc;
    exp_t e;
    ncyc = 3000;
    for (int r = 0; r < NR; r++) begin has[r] = 0; seqc[r] = 0; waitc[r] = 0; starve[r] = 0; end
    for (int cyc = 0; cyc < ncyc + 40; cyc++) begin
      @(negedge clk);
      for (int b = 0; b < NB; b++) rdy[b] = (cyc >= ncyc) || ($urandom_range(3) != 0);
      for (int r = 0; r < NR; r++) begin
        if (!has[r] && cyc < ncyc && $urandom_range(1) == 1) begin
          cur[r].b    = $urandom_range(NB - 1);
          cur[r].seq  = seqc[r];
          cur[r].addr = 16'(($urandom_range(8191) << 3) | cur[r].b);
          cur[r].id   = 3'($urandom);
          cur[r].data = {8'(r), 8'(cur[r].b), 16'(seqc[r]), 32'($urandom)};
          cur[r].be   = ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom);
          seqc[r]++; has[r] = 1; waitc[r] = 0;
        end
        req[r] = has[r]; addr[r] = cur[r].addr; id[r] = cur[r].id;
        wdata[r] = cur[r].data; be[r] = cur[r].be;
      end
      #1;
      n_chk++; if ((gnt & ~req) !== '0) $display("FAIL rand_gnt_no_req got gnt=%b req=%b", gnt, req); else n_pass++;
      // Writes leaving the banks this edge.
      for (int b = 0; b < NB; b++) begin
        if (we[b] && rdy[b]) begin
          w = int'(b_wdata[b][63:56]);
          k = -1;
          if (w < NR) begin
            for (int i = 0; i < outq[w].size(); i++) if (k < 0 && outq[w][i].b == b) k = i;
          end
          n_chk++;
          if (k < 0) begin
            $display("FAIL rand_write bank %0d unexpected data=%h", b, b_wdata[b]);
          end else begin
            e = outq[w][k];
            if (b_addr[b] !== (e.addr >> 3) || b_wdata[b] !== e.data || b_be[b] !== e.be || b_id[b] !== e.id)
              $display("FAIL rand_write bank %0d got data=%h addr=%h want data=%h addr=%h",
                       b, b_wdata[b], b_addr[b], e.data, e.addr >> 3);
            else n_pass++;
            for (int r = 0; r < NR; r++) begin
              if (r != w && outq[r].size() > 0 && outq[r][0].b == b) begin
                starve[r]++;
                n_chk++;
                if (starve[r] > NR) $display("FAIL rand_fair req %0d bypassed %0d times", r, starve[r]);
                else n_pass++;
              end
            end
            if (k == 0) starve[w] = 0;
            outq[w].delete(k);
          end
        end
      end
      // Writes accepted this edge.
      for (int r = 0; r < NR; r++) begin
        if (gnt[r]) begin
          outq[r].push_back(cur[r]); has[r] = 0;
        end else if (has[r]) begin
          waitc[r]++;
          if (waitc[r] == 200) begin
            n_chk++; $display("FAIL rand_liveness req %0d waited %0d cycles want <200", r, waitc[r]);
          end
        end
      end
    end
    idle();
    for (int r = 0; r < NR; r++) begin
      n_chk++;
      if (outq[r].size() !== 0) $display("FAIL rand_loss req %0d has %0d unwritten want 0", r, outq[r].size());
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_bank_conflict();
    test_parallel();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
